// File: rtl/uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_fifo
// Description : UART receive datapath. Deserialises Rx LSB-first on the FSM
//               shift strobe, queues completed bytes in a small first-word
//               fall-through FIFO, and tracks overrun / framing-error status
//               for the CPU-side valid/ready read port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2,
  parameter int ERRCNT_W   = 8
) (
  input  logic                CLOCK,
  input  logic                reset_n,
  input  logic                Rx,
  input  logic                shift,
  input  logic                load_buffer,
  input  logic                SFE,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [ADDR_W:0]     fifo_count,
  output logic                overrun,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                clr_err
);

  localparam logic [ADDR_W:0]     c_DEPTH   = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ERRCNT_W-1:0] c_ERR_MAX = '1;

  logic [DATA_W-1:0]   r_sr;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_overrun;
  logic                r_frame_err;
  logic [ERRCNT_W-1:0] r_err_count;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_rd_ptr_nxt;
  logic [ADDR_W:0]     w_count_nxt;
  logic [DATA_W-1:0]   w_head_nxt;
  logic [ERRCNT_W-1:0] w_err_base;
  logic [ERRCNT_W-1:0] w_err_nxt;
  logic                w_overrun_nxt;
  logic                w_frame_err_nxt;

  // Handshake and occupancy decode; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    w_full  = (r_count == c_DEPTH);
    w_empty = (r_count == '0);
    w_pop   = !w_empty && rd_ready;
    w_push  = load_buffer && (!w_full || w_pop);
    w_drop  = load_buffer && w_full && !w_pop;
  end

  // Next read pointer, occupancy, and the word that will sit at the head after this edge.
  always_comb begin
    w_rd_ptr_nxt = w_pop ? ADDR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
    // The head slot is the one being written this cycle only when the FIFO is
    // (or becomes) one deep; otherwise it is already in memory.
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = r_sr;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Sticky status: a same-cycle event wins over a clear.
  always_comb begin
    w_err_base      = clr_err ? '0 : r_err_count;
    w_err_nxt       = (SFE && (w_err_base != c_ERR_MAX)) ? w_err_base + 1'b1 : w_err_base;
    w_overrun_nxt   = w_drop || (r_overrun && !clr_err);
    w_frame_err_nxt = SFE || (r_frame_err && !clr_err);
  end

  // Storage array; never reset because reads only ever see slots written since reset.
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_sr;
    end
  end

  // Shift register, pointers, registered head word and status flags.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_sr        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (shift) begin
        r_sr <= {Rx, r_sr[DATA_W-1:1]};
      end
      if (w_push) begin
        r_wr_ptr <= ADDR_W'(r_wr_ptr + 1'b1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      // Head word is held when the FIFO goes empty so rd_data keeps its last value.
      if (w_count_nxt != '0) begin
        r_rd_data <= w_head_nxt;
      end
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  // Outputs come straight from registers; no input-to-output combinational path.
  always_comb begin
    rd_data    = r_rd_data;
    rd_valid   = (r_count != '0);
    fifo_count = r_count;
    overrun    = r_overrun;
    frame_err  = r_frame_err;
    err_count  = r_err_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_byte_fifo
// Description : Scoreboard bench for uart_rx_byte_fifo. Stimulus queues the
//               expected bytes; an independent monitor pops and compares on
//               every accepted read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte_fifo;

  logic       CLOCK = 1'b0;
  logic       reset_n;
  logic       Rx;
  logic       shift;
  logic       load_buffer;
  logic       SFE;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_err;
  logic [7:0] err_count;
  logic       clr_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  uart_rx_byte_fifo #(
    .DATA_W(8), .FIFO_DEPTH(4), .ADDR_W(2), .ERRCNT_W(8)
  ) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .Rx(Rx), .shift(shift),
    .load_buffer(load_buffer), .SFE(SFE), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .err_count(err_count),
    .clr_err(clr_err)
  );

  // 20 ns clock period
  always #10 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read must match the oldest expected byte.
  always @(negedge CLOCK) begin
    if (reset_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      Rx    = b[i];
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
    Rx    = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    shift_byte(b);
    load_buffer = 1'b1;
    if (accepted) exp_q.push_back(b);
    tick();
    load_buffer = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; Rx = 1'b1; shift = 1'b0; load_buffer = 1'b0;
    SFE = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_count", 32'(err_count), 0);

    // 1. Single byte 0xA5, then read it
    push_byte(8'hA5, 1'b1);
    chk("t1_rd_valid", 32'(rd_valid), 1);
    chk("t1_rd_data", 32'(rd_data), 32'h A5);
    chk("t1_count", 32'(fifo_count), 1);
    drain(1);
    chk("t1_rd_valid_after", 32'(rd_valid), 0);
    chk("t1_count_after", 32'(fifo_count), 0);
    chk("t1_rd_data_hold", 32'(rd_data), 32'hA5);

    // 1b. Push with a same-cycle shift captures the pre-shift byte
    shift_byte(8'h5A);
    Rx = 1'b1; shift = 1'b1; load_buffer = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    shift = 1'b0;
    exp_q.push_back(8'hAD);   // {1, 0x5A >> 1}
    tick();
    load_buffer = 1'b0;
    chk("t1b_count", 32'(fifo_count), 2);
    drain(2);

    // 2. Fill to four, overflow with 0x05, drain in order
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    push_byte(8'h04, 1'b1);
    chk("t2_count_full", 32'(fifo_count), 4);
    chk("t2_overrun_pre", 32'(overrun), 0);
    push_byte(8'h05, 1'b0);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_count_after_ovf", 32'(fifo_count), 4);
    drain(4);
    chk("t2_count_drained", 32'(fifo_count), 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t2_overrun_clr", 32'(overrun), 0);

    // 3. Full FIFO: push and pop in the same cycle
    push_byte(8'h21, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h23, 1'b1);
    push_byte(8'h24, 1'b1);
    shift_byte(8'h66);
    load_buffer = 1'b1; rd_ready = 1'b1;
    exp_q.push_back(8'h66);
    tick();
    load_buffer = 1'b0; rd_ready = 1'b0;
    chk("t3_count", 32'(fifo_count), 4);
    chk("t3_overrun", 32'(overrun), 0);
    drain(4);
    chk("t3_count_drained", 32'(fifo_count), 0);

    // 4a. load_buffer and SFE together: both actions happen
    shift_byte(8'h3C);
    load_buffer = 1'b1; SFE = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    load_buffer = 1'b0; SFE = 1'b0;
    chk("t4a_count", 32'(fifo_count), 1);
    chk("t4a_err_count", 32'(err_count), 1);
    drain(1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // 4. Framing errors: count, saturate, clear
    SFE = 1'b1; repeat (3) tick(); SFE = 1'b0;
    chk("t4_err_count3", 32'(err_count), 3);
    chk("t4_frame_err", 32'(frame_err), 1);
    chk("t4_count", 32'(fifo_count), 0);
    SFE = 1'b1; repeat (300) tick(); SFE = 1'b0;
    chk("t4_err_sat", 32'(err_count), 255);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t4_clr_overrun", 32'(overrun), 0);
    chk("t4_clr_frame_err", 32'(frame_err), 0);
    chk("t4_clr_err_count", 32'(err_count), 0);
    SFE = 1'b1; tick();
    SFE = 1'b1; clr_err = 1'b1; tick();
    SFE = 1'b0; clr_err = 1'b0;
    chk("t4_clr_sfe_count", 32'(err_count), 1);
    chk("t4_clr_sfe_flag", 32'(frame_err), 1);

    // 5. Asynchronous reset discards queued bytes
    push_byte(8'hC3, 1'b1);
    push_byte(8'h7E, 1'b1);
    chk("t5_count_pre", 32'(fifo_count), 2);
    chk("t5_rd_data_pre", 32'(rd_data), 32'hC3);
    #2 reset_n = 1'b0;
    #2;
    chk("t5_async_rd_valid", 32'(rd_valid), 0);
    chk("t5_async_count", 32'(fifo_count), 0);
    chk("t5_async_rd_data", 32'(rd_data), 0);
    chk("t5_async_err_count", 32'(err_count), 0);
    chk("t5_async_frame_err", 32'(frame_err), 0);
    exp_q.delete();
    #2 reset_n = 1'b1;
    tick();
    chk("t5_rd_valid_after", 32'(rd_valid), 0);
    chk("t5_count_after", 32'(fifo_count), 0);

    // 6. Pointer wrap-around: ten push/pop pairs
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h10 + 8'(i), 1'b1);
      drain(1);
    end
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
